// File: rtl/instruction_sequencer_if.sv
// Bundle between instruction_sequencer and its neighbours: the decoder fetch
// handshake, the start/status lines and the decoded regfile/ALU controls.
interface instruction_sequencer_if;
    logic        start;
    logic [31:0] instruction;
    logic        fetch_en;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [15:0] imm;
    logic [2:0]  alu_op;
    logic        use_imm;
    logic        rf_we;
    logic        busy;
    logic        halted;
    logic [5:0]  instr_count;
    logic [2:0]  fsm_state;

    modport master (
        input  start,
        input  instruction,
        output fetch_en,
        output rs_addr,
        output rt_addr,
        output rd_addr,
        output imm,
        output alu_op,
        output use_imm,
        output rf_we,
        output busy,
        output halted,
        output instr_count,
        output fsm_state
    );

    modport slave (
        output start,
        output instruction,
        input  fetch_en,
        input  rs_addr,
        input  rt_addr,
        input  rd_addr,
        input  imm,
        input  alu_op,
        input  use_imm,
        input  rf_we,
        input  busy,
        input  halted,
        input  instr_count,
        input  fsm_state
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer in front of the decoder;
// splits the captured word into regfile/ALU controls and halts on a zero word.
module instruction_sequencer #(
    parameter int MAX_INSTR   = 32,
    parameter int EXEC_CYCLES = 1
) (
    input logic              clk,
    input logic              reset,
    instruction_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [3:0] EXEC_LAST   = 4'(EXEC_CYCLES - 1);
    localparam logic [5:0] COUNT_LIMIT = 6'(MAX_INSTR);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] ir;
    logic [3:0]  exec_cnt;
    logic [5:0]  instr_count;
    logic [5:0]  count_inc;

    assign count_inc = instr_count + 6'd1;

    // Fetch handshake: fetch_en is a one-cycle request with no ready; the decoder
    // answers with the word on the following cycle (our DECODE) and drives zero
    // otherwise, so the word is sampled only in DECODE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (bus.start) state_next = S_FETCH;
            S_FETCH:     state_next = S_DECODE;
            S_DECODE:    state_next = (bus.instruction == 32'd0) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   if (exec_cnt == EXEC_LAST) state_next = S_WRITEBACK;
            S_WRITEBACK: state_next = (count_inc == COUNT_LIMIT) ? S_HALT : S_FETCH;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ir          <= 32'd0;
            exec_cnt    <= 4'd0;
            instr_count <= 6'd0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                ir       <= bus.instruction;
                exec_cnt <= 4'd0;
            end
            if (state == S_EXECUTE && exec_cnt != EXEC_LAST) begin
                exec_cnt <= exec_cnt + 4'd1;
            end
            // The guard keeps the count saturated even though WRITEBACK at the
            // limit always leads to HALT.
            if (state == S_WRITEBACK && instr_count != COUNT_LIMIT) begin
                instr_count <= count_inc;
            end
        end
    end

    assign bus.fetch_en    = (state == S_FETCH);
    assign bus.rf_we       = (state == S_WRITEBACK);
    assign bus.busy        = (state == S_FETCH) || (state == S_DECODE) ||
                             (state == S_EXECUTE) || (state == S_WRITEBACK);
    assign bus.halted      = (state == S_HALT);
    assign bus.instr_count = instr_count;
    assign bus.fsm_state   = state;

    // Opcodes 110/111 are I-type: destination is the rt field.
    assign bus.use_imm = (ir[31:30] == 2'b11);
    assign bus.alu_op  = ir[31:29];
    assign bus.rs_addr = ir[28:24];
    assign bus.rt_addr = ir[23:19];
    assign bus.rd_addr = bus.use_imm ? ir[23:19] : ir[18:14];
    assign bus.imm     = ir[15:0];
endmodule
